// File: rtl/alu_op_sequencer_if.sv
// Command channel into the ALU op sequencer: opcode/operand offered
// under a valid/ready handshake.
interface alu_op_sequencer_if;
    logic       cmd_valid;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/alu_op_sequencer.sv
// Command front-end for the 8-bit accumulator ALU. Buffers commands in a
// small FIFO, presents one op at a time on the ALU pins (holding a DIV for
// its whole multi-cycle sequence), drives OR #0 as a harmless NOP when idle,
// reports committed results and flags loss of lock with the ALU FSM.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_ISSUE   | every edge loads the FIFO head (popping it) or a NOP
// S_DIVHOLD | DIV held on the pins, dcnt tracks the ALU state 0..DIV_CYCLES-1;
//           | on the last count the next op is issued at the same edge
module alu_op_sequencer #(
    parameter int DEPTH      = 4,
    parameter int DIV_CYCLES = 9
) (
    input  logic                       clk,
    input  logic                       reset,
    alu_op_sequencer_if.slave          cmd,
    output logic [2:0]                 alu_opcode,
    output logic [7:0]                 alu_in,
    input  logic [3:0]                 alu_current,
    input  logic [7:0]                 alu_acc,
    output logic                       res_valid,
    output logic [7:0]                 res_data,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       sync_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd5;

    localparam logic [0:0] S_ISSUE   = 1'b0;
    localparam logic [0:0] S_DIVHOLD = 1'b1;

    logic [2:0]    fifo_op   [DEPTH];
    logic [7:0]    fifo_data [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [0:0]    state;
    logic [DW-1:0] dcnt;
    logic          real_op;

    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic          div_last;
    logic          issue_now;
    logic [2:0]    next_op;
    logic [7:0]    next_data;
    logic          next_real;
    logic [3:0]    exp_current;

    assign fifo_count    = count;
    assign fifo_empty    = (count == '0);
    assign cmd.cmd_ready = (count != CW'(DEPTH)) & ~reset;
    assign push          = cmd.cmd_valid & cmd.cmd_ready;

    // The last DIV cycle behaves like ISSUE so the next op follows with no bubble.
    assign div_last    = (state == S_DIVHOLD) && (dcnt == DW'(DIV_CYCLES - 1));
    assign issue_now   = (state == S_ISSUE) || div_last;
    assign pop         = issue_now & ~fifo_empty;

    assign busy        = ~fifo_empty | real_op;
    assign res_data    = alu_acc;
    assign exp_current = (state == S_DIVHOLD) ? 4'(dcnt) : 4'd0;

    // Select what the pins get at the next issue: FIFO head or NOP.
    always_comb begin
        next_op   = OP_OR;
        next_data = 8'h00;
        next_real = 1'b0;
        if (!fifo_empty) begin
            next_op   = fifo_op[rd_ptr];
            next_data = fifo_data[rd_ptr];
            next_real = 1'b1;
        end
    end

    // FIFO storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op[wr_ptr]   <= cmd.cmd_op;
            fifo_data[wr_ptr] <= cmd.cmd_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Issue FSM: load the ALU pins, or hold them while a DIV runs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_ISSUE;
            dcnt       <= '0;
            alu_opcode <= OP_OR;
            alu_in     <= 8'h00;
            real_op    <= 1'b0;
        end else if (issue_now) begin
            alu_opcode <= next_op;
            alu_in     <= next_data;
            real_op    <= next_real;
            dcnt       <= '0;
            state      <= (next_op == OP_DIV) ? S_DIVHOLD : S_ISSUE;
        end else begin
            dcnt       <= dcnt + 1'b1;
        end
    end

    // Result pulse after a real op's commit edge, and sticky lock check.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            res_valid <= real_op & issue_now;
            if (alu_current != exp_current) sync_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a small accumulator ALU model closes the loop,
// a monitor checks every res_valid against hand-computed expectations.
module tb_alu_op_sequencer;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_LOAD = 3'd4;
    localparam logic [2:0] OP_DIV  = 3'd5;
    localparam logic [2:0] OP_MUL  = 3'd6;
    localparam logic [2:0] OP_NOT  = 3'd7;

    typedef struct {
        logic [2:0] op;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] alu_opcode;
    logic [7:0] alu_in;
    logic [3:0] alu_current;
    logic [7:0] alu_acc;
    logic       res_valid;
    logic [7:0] res_data;
    logic       busy;
    logic [2:0] fifo_count;
    logic       sync_err;

    logic [3:0] model_cur;
    logic       force_cur;
    logic [3:0] force_val;
    logic       stall_seen;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    logic [7:0] exp_q [$];
    int         res_cyc [$];

    vec_t vec   [9];
    vec_t wrapv [6];

    always #5 clk = ~clk;

    alu_op_sequencer_if cmd_if();

    assign alu_current = force_cur ? force_val : model_cur;

    alu_op_sequencer #(.DEPTH(4), .DIV_CYCLES(9)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd         (cmd_if),
        .alu_opcode  (alu_opcode),
        .alu_in      (alu_in),
        .alu_current (alu_current),
        .alu_acc     (alu_acc),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .sync_err    (sync_err)
    );

    function automatic logic [7:0] div8(input logic [7:0] a, input logic [7:0] b);
        if (b == 8'h00) return 8'hFF;
        return a / b;
    endfunction

    // Accumulator ALU model: single-cycle ops in state 0, DIV walks states 1..8.
    always @(posedge clk) begin
        if (reset) begin
            alu_acc   <= 8'h00;
            model_cur <= 4'd0;
        end else if (model_cur != 4'd0) begin
            if (model_cur == 4'd8) begin
                alu_acc   <= div8(alu_acc, alu_in);
                model_cur <= 4'd0;
            end else begin
                model_cur <= model_cur + 4'd1;
            end
        end else begin
            case (alu_opcode)
                OP_ADD:  alu_acc <= alu_acc + alu_in;
                OP_SUB:  alu_acc <= alu_acc - alu_in;
                OP_AND:  alu_acc <= alu_acc & alu_in;
                OP_OR:   alu_acc <= alu_acc | alu_in;
                OP_LOAD: alu_acc <= alu_in;
                OP_DIV:  model_cur <= 4'd1;
                OP_MUL:  alu_acc <= 8'(alu_acc * alu_in);
                default: alu_acc <= ~alu_acc;
            endcase
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every result pulse must match the next expected accumulator value.
    always @(negedge clk) begin
        if (res_valid === 1'b1) begin
            res_cyc.push_back(cyc);
            if (exp_q.size() == 0) chk("res_valid_unexpected", res_valid, 0);
            else                   chk("res_data", res_data, exp_q.pop_front());
        end
    end

    task automatic push(input logic [2:0] op, input logic [7:0] d);
        int n = 0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_data  = d;
        while (cmd_if.cmd_ready !== 1'b1 && n < 50) begin
            stall_seen = 1'b1;
            chk("ready_low_only_when_full", fifo_count, 4);
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("push_timeout", n, 0);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", n < 200, 1);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int div_len;
        int segs;
        logic in_div;
        int n;

        reset            = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 3'd0;
        cmd_if.cmd_data  = 8'h00;
        force_cur        = 1'b0;
        force_val        = 4'd0;
        stall_seen       = 1'b0;

        vec[0] = '{OP_LOAD, 8'h05, 8'h05};
        vec[1] = '{OP_ADD,  8'h03, 8'h08};
        vec[2] = '{OP_SUB,  8'h01, 8'h07};
        vec[3] = '{OP_NOT,  8'h00, 8'hF8};
        vec[4] = '{OP_AND,  8'h3C, 8'h38};
        vec[5] = '{OP_OR,   8'h41, 8'h79};
        vec[6] = '{OP_MUL,  8'h03, 8'h6B};
        vec[7] = '{OP_SUB,  8'h80, 8'hEB};
        vec[8] = '{OP_ADD,  8'h20, 8'h0B};

        wrapv[0] = '{OP_ADD, 8'h01, 8'h41};
        wrapv[1] = '{OP_ADD, 8'h02, 8'h43};
        wrapv[2] = '{OP_SUB, 8'h03, 8'h40};
        wrapv[3] = '{OP_OR,  8'h0F, 8'h4F};
        wrapv[4] = '{OP_AND, 8'hF0, 8'h40};
        wrapv[5] = '{OP_NOT, 8'h00, 8'hBF};

        // Reset held two cycles
        repeat (2) begin
            @(negedge clk);
            chk("rst_opcode", alu_opcode, 3);
            chk("rst_in", alu_in, 0);
            chk("rst_ready", cmd_if.cmd_ready, 0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", cmd_if.cmd_ready, 1);
        chk("post_rst_count", fifo_count, 0);
        chk("post_rst_res_valid", res_valid, 0);
        chk("post_rst_sync_err", sync_err, 0);
        chk("post_rst_busy", busy, 0);

        // Back-to-back non-DIV ops
        res_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(vec[i].exp);
            push(vec[i].op, vec[i].data);
            if (i == 0) begin
                chk("b2b_busy", busy, 1);
                chk("b2b_count", fifo_count, 1);
            end else begin
                chk("b2b_opcode", alu_opcode, vec[i-1].op);
                chk("b2b_in", alu_in, vec[i-1].data);
            end
        end
        wait_idle();
        chk("b2b_res_count", res_cyc.size(), 4);
        if (res_cyc.size() == 4)
            for (int i = 1; i < 4; i++) chk("b2b_res_contiguous", res_cyc[i] - res_cyc[i-1], 1);
        chk("b2b_nop_opcode", alu_opcode, 3);
        chk("b2b_nop_in", alu_in, 0);
        chk("b2b_acc_hold", alu_acc, 8'hF8);

        // Remaining single ops, one at a time
        for (int i = 4; i < 9; i++) begin
            exp_q.push_back(vec[i].exp);
            push(vec[i].op, vec[i].data);
            wait_idle();
            chk("table_acc", alu_acc, vec[i].exp);
        end

        // DIV hold: LOAD 40, DIV 20, ADD 01
        res_cyc.delete();
        exp_q.push_back(8'h40); push(OP_LOAD, 8'h40);
        exp_q.push_back(8'h02); push(OP_DIV,  8'h20);
        exp_q.push_back(8'h03); push(OP_ADD,  8'h01);
        div_len = 0;
        segs    = 0;
        in_div  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (alu_opcode == OP_DIV && alu_in == 8'h20) begin
                if (!in_div) segs++;
                in_div = 1'b1;
                chk("div_current_step", alu_current, div_len);
                div_len++;
            end else begin
                in_div = 1'b0;
            end
            @(negedge clk);
        end
        wait_idle();
        chk("div_hold_len", div_len, 9);
        chk("div_hold_segments", segs, 1);
        chk("div_sync_err", sync_err, 0);
        chk("div_res_count", res_cyc.size(), 3);
        if (res_cyc.size() == 3) begin
            chk("div_res_gap", res_cyc[1] - res_cyc[0], 9);
            chk("div_add_follow", res_cyc[2] - res_cyc[1], 1);
        end
        chk("div_acc", alu_acc, 8'h03);

        // Full/wrap: six commands offered while a DIV holds
        stall_seen = 1'b0;
        exp_q.push_back(8'h80); push(OP_LOAD, 8'h80);
        exp_q.push_back(8'h40); push(OP_DIV,  8'h02);
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(wrapv[i].exp);
            push(wrapv[i].op, wrapv[i].data);
        end
        wait_idle();
        chk("wrap_stall_seen", stall_seen, 1);
        chk("wrap_acc", alu_acc, 8'hBF);
        chk("wrap_sync_err", sync_err, 0);

        // Reset during DIV cycle 4
        exp_q.push_back(8'h40); push(OP_LOAD, 8'h40);
        push(OP_DIV, 8'h20);
        push(OP_ADD, 8'h01);
        n = 0;
        while (!(alu_opcode == OP_DIV && alu_current == 4'd4) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("middiv_reached", n < 50, 1);
        chk("middiv_pending", fifo_count, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("middiv_opcode", alu_opcode, 3);
        chk("middiv_in", alu_in, 0);
        chk("middiv_count", fifo_count, 0);
        chk("middiv_res_valid", res_valid, 0);
        chk("middiv_busy", busy, 0);
        chk("middiv_ready", cmd_if.cmd_ready, 0);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        chk("middiv_no_results", exp_q.size(), 0);
        chk("middiv_idle", busy, 0);
        chk("middiv_acc", alu_acc, 0);

        // Lock loss during NOP
        chk("lock_pre", sync_err, 0);
        force_val = 4'd3;
        force_cur = 1'b1;
        @(negedge clk);
        force_cur = 1'b0;
        chk("lock_set", sync_err, 1);
        repeat (3) @(negedge clk);
        chk("lock_sticky", sync_err, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("lock_cleared", sync_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command front-end that sits directly upstream of the 8-bit accumulator ALU (the `sramdemo` top with its NR divider).

- Buffers opcode/operand commands in a small FIFO behind a valid/ready handshake.
- Presents one command at a time on the ALU's `opcode`/`in` pins and holds a DIV command for its full 9-cycle sequence.
- Drives a harmless NOP when idle, so the accumulator is never disturbed.
- Reports each completed operation with the updated accumulator value, and flags any loss of lock with the ALU state machine.

## Interface
- `DEPTH`, default 4: FIFO entries; power of 2, ≥2.
- `DIV_CYCLES`, default 9: cycles a DIV occupies the ALU (Ssingle + Sdiv2..Sdiv9).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: command offered.
- `cmd_op` in 3: opcode (0 ADD, 1 SUB, 2 AND, 3 OR, 4 LOAD, 5 DIV, 6 MUL, 7 NOT).
- `cmd_data` in 8: operand.
- `cmd_ready` out 1: FIFO can accept.
- `alu_opcode` out 3: to ALU `opcode`, registered.
- `alu_in` out 8: to ALU `in`, registered.
- `alu_current` in 4: ALU `current` state.
- `alu_acc` in 8: ALU `acc`.
- `res_valid` out 1: one-cycle pulse, real operation committed.
- `res_data` out 8: equals `alu_acc` while `res_valid`.
- `busy` out 1: FIFO non-empty or real op on ALU pins.
- `fifo_count` out 3: entries held, 0..DEPTH.
- `sync_err` out 1: sticky ALU state mismatch.

## Operation
- **FIFO.**
  - Push on `cmd_valid & cmd_ready`.
  - `cmd_ready = (fifo_count != DEPTH) & ~reset`.
  - No bypass: a pushed entry becomes visible to the issue logic at the next edge.
  - Push and pop in the same cycle leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
- **NOP.** `alu_opcode=3 (OR)`, `alu_in=8'h00`. The ALU computes acc|0, so acc is unchanged. A NOP never produces `res_valid`.
- **State machine.** The issue FSM has two states, ISSUE and DIVHOLD, plus a counter `dcnt` (0..DIV_CYCLES-1).
  - **ISSUE:** at each edge, load the output registers.
    - FIFO non-empty: load the FIFO head and pop it.
    - FIFO empty: load NOP.
    - If the loaded op is DIV: clear `dcnt` and go to DIVHOLD.
  - **DIVHOLD:** hold the output registers unchanged and increment `dcnt`. No pop occurs.
    - When `dcnt == DIV_CYCLES-1` at the edge, take the ISSUE action at that same edge (load next head or NOP) and leave DIVHOLD.
- **Commit rule.** A non-DIV op presented during cycle k commits at the end of cycle k. A DIV commits at the end of its 9th presented cycle.
  - `res_valid` is registered: high during the cycle after a real op's commit edge.
  - `res_data` is combinationally `alu_acc` (already updated in that cycle).
- **Lock check.** Every cycle outside reset, compare against the expected state:
  - `alu_current` must equal `dcnt` while in DIVHOLD or on a DIV's first presented cycle.
  - Otherwise it must equal 0.
  - Any mismatch sets `sync_err`, which is cleared only by reset.
- **Reset.**
  - FIFO flushed, state = ISSUE, `dcnt=0`.
  - `alu_opcode=3`, `alu_in=0`, `res_valid=0`, `busy=0`, `fifo_count=0`, `sync_err=0`.
  - `cmd_ready=0` while `reset` is high.
  - A reset mid-DIV aborts the DIV with no `res_valid`. The ALU is reset by the same signal.

## Timing
- **Push to ALU.** Push at edge P → op on the ALU pins from P+1 → commit at P+2 → `res_valid` during cycle P+2..P+3.
- **Throughput.**
  - Non-DIV ops: one per cycle back-to-back, with `res_valid` continuous.
  - DIV: `alu_opcode=5` and `alu_in` are held stable for exactly 9 cycles. The next command appears at the 9th edge with no bubble.
- **While DIV holds.** `cmd_ready` still accepts pushes until the FIFO is full. With FIFO full and a push offered, `cmd_ready=0` and the entry is not lost.
- **busy.** Falls in the first cycle in which NOP is presented and the FIFO is empty.

## Test plan
- **Reset.** Hold `reset` 2 cycles → `alu_opcode=3`, `alu_in=00`, `cmd_ready=0`; after release `cmd_ready=1`, `fifo_count=0`, no `res_valid`, `sync_err=0`.
- **Back-to-back.** Push LOAD 05, ADD 03, SUB 01, NOT 00 on consecutive cycles → ops reach the ALU on consecutive cycles; `res_data` = 05, 08, 07, F8 on consecutive `res_valid` cycles; then NOP; acc stays F8.
- **DIV hold.** Push LOAD 40, then DIV 20, then ADD 01 → `alu_opcode=5` and `alu_in=20` for exactly 9 cycles; `alu_current` steps 0..8; `sync_err` stays 0; the DIV `res_valid` arrives 9 cycles after the LOAD's; the ADD result equals the DIV result + 1 on the next cycle.
- **Full/wrap.** During a DIV push 6 commands with `cmd_valid` held high → `cmd_ready` drops at `fifo_count=4`, the remaining 2 are accepted as slots free, and all 6 issue in order with pointers wrapped.
- **Mid-DIV reset.** Assert `reset` at DIV cycle 4 → no `res_valid`; FIFO flushed; outputs back to NOP/reset values the following cycle.
- **Lock loss.** Force `alu_current=3` during NOP for 1 cycle → `sync_err=1` from the next cycle and sticky until `reset`.
